// File: rtl/jt89_wr_seq.sv
// Host-side write sequencer for the jt89 PSG: queues register commands and
// serialises them into latch/data bytes with spaced wr_n strobes.
module jt89_wr_seq #(
   parameter int DEPTH   = 4,
   parameter int WR_LOW  = 2,
   parameter int WR_HIGH = 2,
   parameter int ELIDE   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_reg,
   input  logic [9:0]               cmd_data,
   input  logic                     psg_ready,
   output logic                     wr_n,
   output logic [7:0]               din,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] LO_LAST = TW'(WR_LOW - 1);
   localparam logic [TW-1:0] HI_LAST = TW'(WR_HIGH - 1);

   typedef enum logic [2:0] {
      IDLE,
      LAT_LO,
      LAT_HI,
      DAT_LO,
      DAT_HI
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            wr_n_q, wr_n_d;
   logic [7:0]      din_q, din_d;
   logic [5:0]      dat_q, dat_d;
   logic            dat_pend_q, dat_pend_d;
   logic [2:0][5:0] shadow_q, shadow_d;
   logic [2:0]      sh_vld_q, sh_vld_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [12:0]     mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [12:0]     head;
   logic [2:0]      head_reg;
   logic [9:0]      head_data;
   logic            is_noise;
   logic            is_tone;
   logic            sh_hit;
   logic [7:0]      latch_byte;

   assign cmd_ready = (cnt_q != CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign fifo_cnt  = cnt_q;
   assign wr_n      = wr_n_q;
   assign din       = din_q;
   assign busy      = (cnt_q != '0) || (state_q != IDLE);

   assign head       = mem_q[rd_ptr_q];
   assign head_reg   = head[12:10];
   assign head_data  = head[9:0];
   assign is_noise   = (head_reg == 3'b110);
   assign is_tone    = !head_reg[0] && !is_noise;
   assign latch_byte = {1'b1, head_reg, is_noise ? {1'b0, head_data[2:0]} : head_data[3:0]};

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_reg, cmd_data};
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Elision compares against the shadow as it stood before this pop.
   always_comb begin
      sh_hit = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (head_reg[2:1] == 2'(i) && sh_vld_q[2'(i)] && shadow_q[2'(i)] == head_data[9:4])
            sh_hit = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      wr_n_d     = wr_n_q;
      din_d      = din_q;
      dat_d      = dat_q;
      dat_pend_d = dat_pend_q;
      shadow_d   = shadow_q;
      sh_vld_d   = sh_vld_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cnt_q != '0 && psg_ready) begin
               pop        = 1'b1;
               din_d      = latch_byte;
               wr_n_d     = 1'b0;
               tmr_d      = '0;
               state_d    = LAT_LO;
               dat_d      = head_data[9:4];
               dat_pend_d = is_tone && !((ELIDE != 0) && sh_hit);
               for (int unsigned i = 0; i < 3; i++) begin
                  if (is_tone && head_reg[2:1] == 2'(i)) begin
                     shadow_d[2'(i)] = head_data[9:4];
                     sh_vld_d[2'(i)] = 1'b1;
                  end
               end
            end
         end
         LAT_LO, DAT_LO: begin
            if (tmr_q == LO_LAST) begin
               wr_n_d  = 1'b1;
               tmr_d   = '0;
               state_d = (state_q == LAT_LO) ? LAT_HI : DAT_HI;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         LAT_HI: begin
            if (tmr_q != HI_LAST) begin
               tmr_d = tmr_q + TW'(1);
            end else if (!dat_pend_q) begin
               tmr_d   = '0;
               state_d = IDLE;
            end else if (psg_ready) begin
               din_d   = {2'b00, dat_q};
               wr_n_d  = 1'b0;
               tmr_d   = '0;
               state_d = DAT_LO;
            end
         end
         DAT_HI: begin
            if (tmr_q != HI_LAST) begin
               tmr_d = tmr_q + TW'(1);
            end else begin
               tmr_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            wr_n_d  = 1'b1;
            tmr_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         wr_n_q     <= 1'b1;
         din_q      <= '0;
         dat_q      <= '0;
         dat_pend_q <= 1'b0;
         shadow_q   <= '0;
         sh_vld_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         wr_n_q     <= wr_n_d;
         din_q      <= din_d;
         dat_q      <= dat_d;
         dat_pend_q <= dat_pend_d;
         shadow_q   <= shadow_d;
         sh_vld_q   <= sh_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_jt89_wr_seq.sv
// Bench for jt89_wr_seq: directed scenarios plus random traffic, scored
// against a byte-stream model and bus-timing monitors.
module tb_jt89_wr_seq;

   localparam int DEPTH   = 4;
   localparam int WR_LOW  = 2;
   localparam int WR_HIGH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       psg_ready = 1'b0;
   logic [2:0] cmd_reg = '0;
   logic [9:0] cmd_data = '0;

   logic       cmd_ready, wr_n, busy;
   logic [7:0] din;
   logic [2:0] fifo_cnt;
   logic       cmd_ready0, wr_n0, busy0;
   logic [7:0] din0;
   logic [2:0] fifo_cnt0;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] exp_q [$];
   logic [7:0] seen_q [$];
   logic [7:0] seen0_q [$];
   int         model_cnt = 0;
   logic [5:0] m_sh [3];
   logic       m_vld [3];

   logic       prev_wr_n = 1'b1;
   logic       prev0 = 1'b1;
   logic [7:0] held = '0;
   logic [8:0] ent;
   int         low_len = 0;
   int         high_len = WR_HIGH;

   jt89_wr_seq #(.DEPTH(DEPTH), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .ELIDE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data), .psg_ready(psg_ready),
      .wr_n(wr_n), .din(din), .busy(busy), .fifo_cnt(fifo_cnt)
   );

   jt89_wr_seq #(.DEPTH(DEPTH), .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .ELIDE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data), .psg_ready(psg_ready),
      .wr_n(wr_n0), .din(din0), .busy(busy0), .fifo_cnt(fifo_cnt0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         m_vld[i] = 1'b0;
         m_sh[i]  = '0;
      end
   endtask

   task automatic model_push(input logic [2:0] r, input logic [9:0] d);
      logic [7:0] lat;
      int ch;
      if (r == 3'd6) lat = {1'b1, r, 1'b0, d[2:0]};
      else           lat = {1'b1, r, d[3:0]};
      exp_q.push_back({1'b1, lat});
      model_cnt++;
      if (r inside {3'd0, 3'd2, 3'd4}) begin
         ch = int'(r) / 2;
         if (!(m_vld[ch] && m_sh[ch] == d[9:4]))
            exp_q.push_back({1'b0, 2'b00, d[9:4]});
         m_sh[ch]  = d[9:4];
         m_vld[ch] = 1'b1;
      end
   endtask

   task automatic tick(input logic v, input logic [2:0] r, input logic [9:0] d, input logic rdy);
      logic acc;
      @(negedge clk);
      #1;
      cmd_valid = v;
      cmd_reg   = r;
      cmd_data  = d;
      psg_ready = rdy;
      acc = v && (model_cnt != DEPTH);
      @(posedge clk);
      if (acc) model_push(r, d);
   endtask

   task automatic idle(input logic rdy);
      tick(1'b0, 3'd0, 10'd0, rdy);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin
         idle(1'b1);
         #1;
         t++;
      end while ((busy || busy0) && t < 300);
      chk({tag, "_idle"}, t < 300, 1);
      chk({tag, "_drain"}, exp_q.size(), 0);
   endtask

   // Byte scoreboard, pulse-width/gap/din-hold monitors and FIFO-level model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("wr_n_in_reset", wr_n, 1);
         prev_wr_n = 1'b1;
         high_len  = WR_HIGH;
      end else begin
         if (!wr_n && prev_wr_n) begin
            chk("gap", high_len >= WR_HIGH, 1);
            seen_q.push_back(din);
            held    = din;
            low_len = 1;
            chk("exp_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               ent = exp_q.pop_front();
               chk("byte", din, ent[7:0]);
               if (ent[8]) model_cnt--;
            end
         end else if (!wr_n) begin
            low_len++;
            chk("din_hold_lo", din, held);
         end else if (!prev_wr_n) begin
            chk("low_width", low_len, WR_LOW);
            high_len = 1;
            chk("din_hold_hi", din, held);
         end else begin
            high_len++;
            if (high_len <= WR_HIGH) chk("din_hold_hi", din, held);
         end
         prev_wr_n = wr_n;
         chk("fifo_cnt", fifo_cnt, model_cnt);
         chk("cmd_ready", cmd_ready, model_cnt != DEPTH);
         if (model_cnt != 0 || !wr_n) chk("busy", busy, 1);
      end
   end

   always @(negedge clk) begin
      if (rst_n && !wr_n0 && prev0) seen0_q.push_back(din0);
      prev0 = rst_n ? wr_n0 : 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      int ph;
      logic ew;
      logic v, rdy;
      logic [2:0] r;
      logic [9:0] d;

      model_reset();
      psg_ready = 1'b1;
      #12;
      chk("rst_wr_n", wr_n, 1);
      chk("rst_din", din, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", fifo_cnt, 0);
      chk("rst_ready", cmd_ready, 1);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Tone0 0x2A5: exact two-byte waveform.
      seen_q.delete();
      tick(1'b1, 3'd0, 10'h2A5, 1'b1);
      #1 chk("t1_wr_n_push", wr_n, 1);
      for (int k = 1; k <= 2 * (WR_LOW + WR_HIGH); k++) begin
         ph = (k - 1) % (WR_LOW + WR_HIGH);
         ew = (ph >= WR_LOW);
         idle(1'b1);
         #1;
         chk("t1_wr_n", wr_n, ew);
         if (!ew) chk("t1_din", din, (k <= WR_LOW + WR_HIGH) ? 8'h85 : 8'h2A);
         chk("t1_busy", busy, 1);
      end
      idle(1'b1);
      #1 chk("t1_busy_end", busy, 0);

      // Single-byte commands: volumes and noise.
      seen_q.delete();
      tick(1'b1, 3'd3, 10'h00C, 1'b1);
      tick(1'b1, 3'd5, 10'h00C, 1'b1);
      tick(1'b1, 3'd6, 10'h005, 1'b1);
      wait_idle("t2");
      chk("t2_n", seen_q.size(), 3);
      chk("t2_bytes", {seen_q[0], seen_q[1], seen_q[2]}, 24'hBCDCE5);

      // Elision on tone1, compared with the non-eliding instance.
      seen_q.delete();
      seen0_q.delete();
      tick(1'b1, 3'd2, 10'h155, 1'b1);
      tick(1'b1, 3'd2, 10'h15A, 1'b1);
      wait_idle("t3");
      chk("t3_n", seen_q.size(), 3);
      chk("t3_bytes", {seen_q[0], seen_q[1], seen_q[2]}, 24'hA515AA);
      chk("t3_n_noelide", seen0_q.size(), 4);
      chk("t3_bytes_noelide", {seen0_q[0], seen0_q[1], seen0_q[2], seen0_q[3]}, 32'hA515AA15);

      // Fill past capacity while the PSG is not ready.
      seen_q.delete();
      for (int i = 0; i < DEPTH + 2; i++) tick(1'b1, 3'd1, 10'(i), 1'b0);
      #1;
      chk("t4_full_cnt", fifo_cnt, DEPTH);
      chk("t4_full_ready", cmd_ready, 0);
      t = 0;
      do begin
         idle(1'b1);
         #1;
         t++;
      end while (wr_n && t < 20);
      chk("t4_first_pop", wr_n, 0);
      chk("t4_ready_back", cmd_ready, 1);
      chk("t4_cnt_after_pop", fifo_cnt, DEPTH - 1);
      wait_idle("t4");
      chk("t4_n", seen_q.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++) chk("t4_order", seen_q[i], 8'h90 + 8'(i));

      // Stall in LAT_HI with psg_ready low.
      tick(1'b1, 3'd4, 10'h3C7, 1'b1);
      idle(1'b1);
      #1;
      chk("t5_lat_lo", {wr_n, din}, {1'b0, 8'hC7});
      repeat (6) idle(1'b0);
      #1;
      chk("t5_stall", {wr_n, din}, {1'b1, 8'hC7});
      idle(1'b1);
      #1;
      chk("t5_resume", {wr_n, din}, {1'b0, 8'h3C});
      wait_idle("t5");

      // Reset during DAT_LO with commands still queued.
      tick(1'b1, 3'd0, 10'h0F1, 1'b1);
      tick(1'b1, 3'd3, 10'h003, 1'b1);
      tick(1'b1, 3'd7, 10'h007, 1'b1);
      t = 0;
      do begin
         idle(1'b1);
         #1;
         t++;
      end while (!(wr_n == 1'b0 && din == 8'h0F) && t < 40);
      chk("t6_in_dat_lo", {wr_n, din}, {1'b0, 8'h0F});
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_wr_n", wr_n, 1);
      chk("t6_cnt", fifo_cnt, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", cmd_ready, 1);
      chk("t6_din", din, 8'h00);
      idle(1'b1);
      idle(1'b1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      seen_q.delete();
      tick(1'b1, 3'd0, 10'h0F1, 1'b1);
      wait_idle("t6");
      chk("t6_n", seen_q.size(), 2);
      chk("t6_bytes", {seen_q[0], seen_q[1]}, 16'h810F);

      // Random traffic with intermittent psg_ready.
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 2) != 0);
         r   = 3'($urandom_range(0, 7));
         d   = {6'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
         rdy = ($urandom_range(0, 4) != 0);
         tick(v, r, d, rdy);
      end
      wait_idle("rand");
      chk("rand_cnt_end", fifo_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
